// File: rtl/cache_req_arbiter_if.sv
// Bundles the requester-side and cache-side buses of cache_req_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface cache_req_arbiter_if #(
    parameter int num_req_p       = 4,
    parameter int addr_width_p    = 32,
    parameter int data_width_p    = 32,
    parameter int load_id_width_p = 11,
    parameter int max_out_p       = 8
);
    localparam int cnt_w = $clog2(max_out_p + 1);

    // Requester side
    logic [num_req_p-1:0]                 req_v_i;
    logic [num_req_p-1:0]                 req_we_i;
    logic [num_req_p*addr_width_p-1:0]    req_addr_i;
    logic [num_req_p*data_width_p-1:0]    req_data_i;
    logic [num_req_p*load_id_width_p-1:0] req_load_id_i;
    logic [num_req_p-1:0]                 req_yumi_o;

    // Cache request side
    logic                       cache_v_o;
    logic                       cache_we_o;
    logic [addr_width_p-1:0]    cache_addr_o;
    logic [data_width_p-1:0]    cache_data_o;
    logic [load_id_width_p-1:0] cache_load_id_o;
    logic                       cache_ready_i;

    // Cache response side
    logic                       cache_resp_v_i;
    logic [data_width_p-1:0]    cache_resp_data_i;
    logic [load_id_width_p-1:0] cache_resp_load_id_i;
    logic                       cache_resp_yumi_o;

    // Routed responses
    logic [num_req_p-1:0]       resp_v_o;
    logic [data_width_p-1:0]    resp_data_o;
    logic [load_id_width_p-1:0] resp_load_id_o;
    logic [num_req_p-1:0]       resp_ready_i;

    // Status
    logic [cnt_w-1:0]           outstanding_o;
    logic                       error_o;

    modport slave (
        input  req_v_i, req_we_i, req_addr_i, req_data_i, req_load_id_i,
        output req_yumi_o,
        output cache_v_o, cache_we_o, cache_addr_o, cache_data_o, cache_load_id_o,
        input  cache_ready_i,
        input  cache_resp_v_i, cache_resp_data_i, cache_resp_load_id_i,
        output cache_resp_yumi_o,
        output resp_v_o, resp_data_o, resp_load_id_o,
        input  resp_ready_i,
        output outstanding_o, error_o
    );

    modport master (
        output req_v_i, req_we_i, req_addr_i, req_data_i, req_load_id_i,
        input  req_yumi_o,
        input  cache_v_o, cache_we_o, cache_addr_o, cache_data_o, cache_load_id_o,
        output cache_ready_i,
        output cache_resp_v_i, cache_resp_data_i, cache_resp_load_id_i,
        input  cache_resp_yumi_o,
        input  resp_v_o, resp_data_o, resp_load_id_o,
        output resp_ready_i,
        input  outstanding_o, error_o
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one in-order cache port among num_req_p requesters;
// an ID FIFO of granted indices steers each in-order response back to its issuer.
module cache_req_arbiter #(
    parameter int num_req_p       = 4,
    parameter int addr_width_p    = 32,
    parameter int data_width_p    = 32,
    parameter int load_id_width_p = 11,
    parameter int max_out_p       = 8
) (
    input logic clk_i,
    input logic reset_i,
    cache_req_arbiter_if.slave bus
);
    localparam int idx_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ptr_w = (max_out_p > 1) ? $clog2(max_out_p) : 1;
    localparam int cnt_w = $clog2(max_out_p + 1);

    // Handshakes: a transfer happens in the cycle where valid and ready/yumi are
    // both high; valid never depends on the matching ready in the same cycle.

    logic [idx_w-1:0] last_q, last_d;
    logic [idx_w-1:0] fifo_mem_q [max_out_p];
    logic [idx_w-1:0] fifo_mem_d [max_out_p];
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic             error_q, error_d;

    logic [idx_w-1:0] winner;
    logic [idx_w-1:0] head;
    logic             full;
    logic             empty;
    logic             cache_v;
    logic             issue_fire;
    logic             resp_present;
    logic             resp_yumi;
    logic [num_req_p-1:0] yumi_vec;
    logic [num_req_p-1:0] resp_v_vec;

    // Scan downward so the nearest requester after last is assigned last and wins.
    function automatic logic [idx_w-1:0] rr_pick(input logic [num_req_p-1:0] v,
                                                 input logic [idx_w-1:0]     last);
        logic [idx_w-1:0] pick;
        int               idx;
        pick = '0;
        for (int k = num_req_p; k >= 1; k--) begin
            idx = (int'(last) + k) % num_req_p;
            if (v[idx]) pick = idx_w'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        winner       = rr_pick(bus.req_v_i, last_q);
        full         = (count_q == cnt_w'(max_out_p));
        empty        = (count_q == '0);
        head         = fifo_mem_q[rd_ptr_q];
        cache_v      = ~reset_i & (|bus.req_v_i) & ~full;
        issue_fire   = cache_v & bus.cache_ready_i;
        resp_present = ~reset_i & bus.cache_resp_v_i & ~empty;
        resp_yumi    = resp_present & bus.resp_ready_i[head];
    end

    always_comb begin
        yumi_vec = '0;
        if (issue_fire) yumi_vec[winner] = 1'b1;
        resp_v_vec = '0;
        if (resp_present) resp_v_vec[head] = 1'b1;
    end

    always_comb begin
        last_d     = last_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + cnt_w'(issue_fire) - cnt_w'(resp_yumi);
        error_d    = error_q | (~reset_i & bus.cache_resp_v_i & empty);
        if (issue_fire) begin
            last_d               = winner;
            fifo_mem_d[wr_ptr_q] = winner;
            wr_ptr_d = (wr_ptr_q == ptr_w'(max_out_p - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (resp_yumi) begin
            rd_ptr_d = (rd_ptr_q == ptr_w'(max_out_p - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q   <= idx_w'(num_req_p - 1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // Storage contents are qualified by the pointers, so no reset is needed here.
    always_ff @(posedge clk_i) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_comb begin
        bus.req_yumi_o        = yumi_vec;
        bus.cache_v_o         = cache_v;
        bus.cache_we_o        = bus.req_we_i[winner];
        bus.cache_addr_o      = bus.req_addr_i[winner*addr_width_p +: addr_width_p];
        bus.cache_data_o      = bus.req_data_i[winner*data_width_p +: data_width_p];
        bus.cache_load_id_o   = bus.req_load_id_i[winner*load_id_width_p +: load_id_width_p];
        bus.cache_resp_yumi_o = resp_yumi;
        bus.resp_v_o          = resp_v_vec;
        bus.resp_data_o       = bus.cache_resp_data_i;
        bus.resp_load_id_o    = bus.cache_resp_load_id_i;
        bus.outstanding_o     = count_q;
        bus.error_o           = error_q;
    end
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: reset/error, single load, a table of
// round-robin/stall/head-of-line vectors, full blocking, and FIFO wrap.
module tb_cache_req_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 11;
  localparam int MO = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cache_req_arbiter_if #(.num_req_p(NR), .addr_width_p(AW), .data_width_p(DW),
                         .load_id_width_p(LW), .max_out_p(MO)) bus ();

  cache_req_arbiter #(.num_req_p(NR), .addr_width_p(AW), .data_width_p(DW),
                      .load_id_width_p(LW), .max_out_p(MO)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req_v;
    logic        ready;
    logic        resp_v;
    logic [3:0]  resp_ready;
    logic [3:0]  exp_yumi;
    logic        exp_cv;
    logic [31:0] exp_addr;
    logic [3:0]  exp_resp_v;
    logic        exp_cyumi;
    logic [3:0]  exp_out;
  } vec_t;

  vec_t vecs [15];
  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_default_payload();
    for (int i = 0; i < NR; i++) begin
      bus.req_addr_i[i*AW +: AW]    = 32'h1000 + 32'(i * 16);
      bus.req_data_i[i*DW +: DW]    = 32'h5000 + 32'(i);
      bus.req_load_id_i[i*LW +: LW] = 11'(i + 1);
    end
    bus.req_we_i = 4'b0000;
  endtask

  task automatic drive(input logic [3:0] req_v, input logic ready,
                       input logic resp_v, input logic [3:0] resp_ready);
    @(negedge clk);
    bus.req_v_i        = req_v;
    bus.cache_ready_i  = ready;
    bus.cache_resp_v_i = resp_v;
    bus.resp_ready_i   = resp_ready;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_v_i = '0;
    bus.cache_resp_v_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_v_i = '0;
    bus.cache_ready_i = 1'b0;
    bus.cache_resp_v_i = 1'b0;
    bus.cache_resp_data_i = '0;
    bus.cache_resp_load_id_i = '0;
    bus.resp_ready_i = '0;
    set_default_payload();

    // row fields: req_v ready resp_v resp_ready | yumi cv addr resp_v cyumi out
    vecs[0]  = '{4'hF, 1'b1, 1'b0, 4'hF, 4'b0001, 1'b1, 32'h1000, 4'b0000, 1'b0, 4'd0};
    vecs[1]  = '{4'hF, 1'b1, 1'b1, 4'hF, 4'b0010, 1'b1, 32'h1010, 4'b0001, 1'b1, 4'd1};
    vecs[2]  = '{4'hF, 1'b1, 1'b1, 4'hF, 4'b0100, 1'b1, 32'h1020, 4'b0010, 1'b1, 4'd1};
    vecs[3]  = '{4'hF, 1'b1, 1'b1, 4'hF, 4'b1000, 1'b1, 32'h1030, 4'b0100, 1'b1, 4'd1};
    vecs[4]  = '{4'hF, 1'b1, 1'b1, 4'hF, 4'b0001, 1'b1, 32'h1000, 4'b1000, 1'b1, 4'd1};
    vecs[5]  = '{4'h0, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 32'h0,    4'b0001, 1'b1, 4'd1};
    vecs[6]  = '{4'hA, 1'b0, 1'b0, 4'hF, 4'b0000, 1'b1, 32'h1010, 4'b0000, 1'b0, 4'd0};
    vecs[7]  = '{4'hA, 1'b0, 1'b0, 4'hF, 4'b0000, 1'b1, 32'h1010, 4'b0000, 1'b0, 4'd0};
    vecs[8]  = '{4'hA, 1'b0, 1'b0, 4'hF, 4'b0000, 1'b1, 32'h1010, 4'b0000, 1'b0, 4'd0};
    vecs[9]  = '{4'hA, 1'b1, 1'b0, 4'hF, 4'b0010, 1'b1, 32'h1010, 4'b0000, 1'b0, 4'd0};
    vecs[10] = '{4'hA, 1'b1, 1'b0, 4'hF, 4'b1000, 1'b1, 32'h1030, 4'b0000, 1'b0, 4'd1};
    vecs[11] = '{4'h0, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 32'h0,    4'b0010, 1'b1, 4'd2};
    vecs[12] = '{4'h0, 1'b1, 1'b1, 4'h7, 4'b0000, 1'b0, 32'h0,    4'b1000, 1'b0, 4'd1};
    vecs[13] = '{4'h0, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 32'h0,    4'b1000, 1'b1, 4'd1};
    vecs[14] = '{4'h0, 1'b1, 1'b0, 4'hF, 4'b0000, 1'b0, 32'h0,    4'b0000, 1'b0, 4'd0};

    // outputs held low while reset is asserted
    drive(4'hF, 1'b1, 1'b1, 4'hF);
    check("rst_cache_v", 64'(bus.cache_v_o), 64'd0);
    check("rst_yumi", 64'(bus.req_yumi_o), 64'd0);
    check("rst_resp_v", 64'(bus.resp_v_o), 64'd0);
    check("rst_cyumi", 64'(bus.cache_resp_yumi_o), 64'd0);

    // response with nothing outstanding sets sticky error
    @(negedge clk);
    rst = 1'b0;
    bus.req_v_i = '0;
    #1;
    check("rst_out", 64'(bus.outstanding_o), 64'd0);
    check("rst_err", 64'(bus.error_o), 64'd0);
    check("err_resp_v", 64'(bus.resp_v_o), 64'd0);
    check("err_cyumi", 64'(bus.cache_resp_yumi_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 1'b1, 1'b0, 4'hF);
      check("err_sticky", 64'(bus.error_o), 64'd1);
    end
    do_reset();
    #1;
    check("err_cleared", 64'(bus.error_o), 64'd0);

    // single load from requester 2
    @(negedge clk);
    bus.req_addr_i[2*AW +: AW] = 32'h100;
    bus.req_load_id_i[2*LW +: LW] = 11'd5;
    bus.req_v_i = 4'b0100;
    bus.cache_ready_i = 1'b1;
    #1;
    check("t1_yumi", 64'(bus.req_yumi_o), 64'b0100);
    check("t1_addr", 64'(bus.cache_addr_o), 64'h100);
    check("t1_id", 64'(bus.cache_load_id_o), 64'd5);
    check("t1_we", 64'(bus.cache_we_o), 64'd0);
    @(negedge clk);
    bus.req_v_i = '0;
    bus.cache_resp_v_i = 1'b1;
    bus.cache_resp_data_i = 32'hDEADBEEF;
    bus.cache_resp_load_id_i = 11'd5;
    bus.resp_ready_i = 4'hF;
    #1;
    check("t1_resp_v", 64'(bus.resp_v_o), 64'b0100);
    check("t1_resp_data", 64'(bus.resp_data_o), 64'hDEADBEEF);
    check("t1_resp_id", 64'(bus.resp_load_id_o), 64'd5);
    check("t1_out1", 64'(bus.outstanding_o), 64'd1);
    drive(4'h0, 1'b1, 1'b0, 4'hF);
    check("t1_out0", 64'(bus.outstanding_o), 64'd0);
    set_default_payload();

    // round robin, stall, head-of-line table
    do_reset();
    for (int r = 0; r < 15; r++) begin
      drive(vecs[r].req_v, vecs[r].ready, vecs[r].resp_v, vecs[r].resp_ready);
      check($sformatf("v%0d_yumi", r), 64'(bus.req_yumi_o), 64'(vecs[r].exp_yumi));
      check($sformatf("v%0d_cv", r), 64'(bus.cache_v_o), 64'(vecs[r].exp_cv));
      if (vecs[r].exp_cv)
        check($sformatf("v%0d_addr", r), 64'(bus.cache_addr_o), 64'(vecs[r].exp_addr));
      check($sformatf("v%0d_resp_v", r), 64'(bus.resp_v_o), 64'(vecs[r].exp_resp_v));
      check($sformatf("v%0d_cyumi", r), 64'(bus.cache_resp_yumi_o), 64'(vecs[r].exp_cyumi));
      check($sformatf("v%0d_out", r), 64'(bus.outstanding_o), 64'(vecs[r].exp_out));
    end

    // fill to max_out, then one release admits one more issue next cycle
    do_reset();
    for (int i = 0; i < MO; i++) begin
      drive(4'b0001, 1'b1, 1'b0, 4'hF);
      check("full_fill_yumi", 64'(bus.req_yumi_o), 64'b0001);
    end
    drive(4'b0001, 1'b1, 1'b0, 4'hF);
    check("full_cv", 64'(bus.cache_v_o), 64'd0);
    check("full_out", 64'(bus.outstanding_o), 64'd8);
    drive(4'b0001, 1'b1, 1'b1, 4'hF);
    check("full_pop_cv", 64'(bus.cache_v_o), 64'd0);
    check("full_pop_cyumi", 64'(bus.cache_resp_yumi_o), 64'd1);
    drive(4'b0001, 1'b1, 1'b0, 4'hF);
    check("full_reissue_out", 64'(bus.outstanding_o), 64'd7);
    check("full_reissue_yumi", 64'(bus.req_yumi_o), 64'b0001);
    drive(4'b0000, 1'b1, 1'b0, 4'hF);
    check("full_again_out", 64'(bus.outstanding_o), 64'd8);
    for (int i = 0; i < MO; i++) begin
      drive(4'b0000, 1'b1, 1'b1, 4'hF);
      check("full_drain_resp_v", 64'(bus.resp_v_o), 64'b0001);
    end
    drive(4'b0000, 1'b1, 1'b0, 4'hF);
    check("full_drain_out", 64'(bus.outstanding_o), 64'd0);

    // steady issue+pop at depth 3 across several FIFO wraps
    do_reset();
    for (int n = 0; n < 23; n++) begin
      logic [1:0] g;
      logic [1:0] h;
      g = 2'(n % 4);
      drive(4'hF, 1'b1, (n >= 3), 4'hF);
      check("wrap_yumi", 64'(bus.req_yumi_o), 64'(4'b0001 << g));
      check("wrap_out", 64'(bus.outstanding_o), 64'((n < 3) ? n : 3));
      if (n >= 3) begin
        h = exp_q.pop_front();
        check("wrap_resp_v", 64'(bus.resp_v_o), 64'(4'b0001 << h));
      end
      exp_q.push_back(g);
    end
    for (int n = 0; n < 3; n++) begin
      logic [1:0] h;
      drive(4'h0, 1'b1, 1'b1, 4'hF);
      h = exp_q.pop_front();
      check("wrap_drain_resp_v", 64'(bus.resp_v_o), 64'(4'b0001 << h));
    end
    drive(4'h0, 1'b1, 1'b0, 4'hF);
    check("wrap_final_out", 64'(bus.outstanding_o), 64'd0);
    check("wrap_no_err", 64'(bus.error_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
